// File: rtl/fifo_flex.sv
// fifo_flex: circular-buffer FIFO with programmable almost-full/empty thresholds,
// sticky overflow/underflow flags and a registered or first-word-fall-through read port.
module fifo_flex #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 3,
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W:0]   thr_af,
    input  logic [ADDR_W:0]   thr_ae,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              pop_acc, push_acc;

    assign full         = (cnt_q == DEPTH_C);
    assign empty        = (cnt_q == '0);
    assign almost_full  = (cnt_q >= thr_af);
    assign almost_empty = (cnt_q <= thr_ae);
    assign count        = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
    always_comb begin
        pop_acc  = pop && !empty;
        push_acc = push && (!full || pop_acc);
        wr_d     = push_acc ? wr_q + 1'b1 : wr_q;
        rd_d     = pop_acc ? rd_q + 1'b1 : rd_q;
        cnt_d    = (push_acc && !pop_acc) ? cnt_q + 1'b1 :
                   (pop_acc && !push_acc) ? cnt_q - 1'b1 : cnt_q;
        dout_d   = pop_acc ? mem_q[rd_q] : dout_q;
        ovf_d    = (push && !push_acc) || (ovf_q && !err_clr);
        unf_d    = (pop && empty) || (unf_q && !err_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_q] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem_q[rd_q];
        end else begin : g_reg
            assign data_out = dout_q;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: registered-read and FWFT instances driven in lockstep and checked
// against a queue-based reference model, plus directed scenarios.
module tb_fifo_flex;
    localparam int DW = 12, AW = 3, DEPTH = 8;

    logic clk = 1'b0, reset = 1'b0, push = 1'b0, pop = 1'b0, err_clr = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [AW:0] thr_af = 4'd6, thr_ae = 4'd1;
    logic [DW-1:0] dout0, dout1;
    logic full0, empty0, af0, ae0, ovf0, unf0;
    logic full1, empty1, af1, ae1, ovf1, unf1;
    logic [AW:0] cnt0, cnt1;

    fifo_flex #(.DATA_W(DW), .ADDR_W(AW), .FWFT(0)) u_reg (
        .clk(clk), .reset(reset), .data_in(data_in), .push(push), .pop(pop),
        .thr_af(thr_af), .thr_ae(thr_ae), .err_clr(err_clr), .data_out(dout0),
        .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(cnt0), .overflow(ovf0), .underflow(unf0));

    fifo_flex #(.DATA_W(DW), .ADDR_W(AW), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .data_in(data_in), .push(push), .pop(pop),
        .thr_af(thr_af), .thr_ae(thr_ae), .err_clr(err_clr), .data_out(dout1),
        .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(cnt1), .overflow(ovf1), .underflow(unf1));

    always #5 clk = ~clk;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    logic m_ovf = 1'b0, m_unf = 1'b0;
    int n_tests = 0, n_fail = 0;

    typedef struct {
        logic          pu;
        logic          po;
        logic [DW-1:0] d;
        logic [AW:0]   cnt;
        logic [DW-1:0] dout;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [DW-1:0] head;
        int n;
        n = q.size();
        head = '0;
        if (n > 0) head = q[0];
        chk("count", cnt0, n);
        chk("count_fwft", cnt1, n);
        chk("empty", empty0, n == 0);
        chk("full", full0, n == DEPTH);
        chk("almost_full", af0, n >= int'(thr_af));
        chk("almost_empty", ae0, n <= int'(thr_ae));
        chk("overflow", ovf0, m_ovf);
        chk("underflow", unf0, m_unf);
        chk("dout_reg", dout0, m_dout);
        chk("dout_fwft", dout1, head);
    endtask

    task automatic cyc(input logic pu, input logic po, input logic [DW-1:0] d, input logic clr);
        bit emp, ful, pa, ua;
        push = pu; pop = po; data_in = d; err_clr = clr;
        emp = (q.size() == 0);
        ful = (q.size() == DEPTH);
        pa  = po && !emp;
        ua  = pu && (!ful || pa);
        @(posedge clk); #1;
        if (pa) m_dout = q.pop_front();
        if (ua) q.push_back(d);
        m_ovf = (pu && !ua) || (m_ovf && !clr);
        m_unf = (po && emp) || (m_unf && !clr);
        push = 0; pop = 0; err_clr = 0;
        check_all();
    endtask

    // Asserted between edges; outputs must clear before any clock edge arrives.
    task automatic async_reset();
        reset = 1'b1;
        #2;
        q.delete();
        m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
        check_all();
        #1 reset = 1'b0;
    endtask

    initial begin
        async_reset();

        tbl[0] = '{1'b1, 1'b0, 12'h00A, 4'd1, 12'h000};
        tbl[1] = '{1'b1, 1'b0, 12'h00B, 4'd2, 12'h000};
        tbl[2] = '{1'b0, 1'b1, 12'h000, 4'd1, 12'h00A};
        tbl[3] = '{1'b0, 1'b0, 12'h000, 4'd1, 12'h00A};
        tbl[4] = '{1'b0, 1'b1, 12'h000, 4'd0, 12'h00B};
        for (int i = 0; i < 5; i++) begin
            cyc(tbl[i].pu, tbl[i].po, tbl[i].d, 1'b0);
            chk("tbl_count", cnt0, tbl[i].cnt);
            chk("tbl_dout", dout0, tbl[i].dout);
        end
        chk("tbl_empty_end", empty0, 1'b1);

        async_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 12'h200 + 12'(i), 1'b0);
            chk("af_rise", af0, (i + 1) >= 6);
            chk("full_rise", full0, (i + 1) == 8);
        end
        cyc(1'b1, 1'b0, 12'h2FF, 1'b0);
        chk("ovf_set", ovf0, 1'b1);
        chk("ovf_count", cnt0, 4'd8);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, '0, 1'b0);
            chk("drain_order", dout0, 12'h200 + 12'(i));
        end
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("ovf_clr", ovf0, 1'b0);

        cyc(1'b0, 1'b1, '0, 1'b0);
        chk("unf_set", unf0, 1'b1);
        chk("unf_dout_hold", dout0, 12'h207);
        cyc(1'b0, 1'b1, '0, 1'b1);
        chk("unf_set_beats_clr", unf0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("unf_clr", unf0, 1'b0);

        cyc(1'b1, 1'b1, 12'h055, 1'b0);
        chk("pushpop_empty_cnt", cnt0, 4'd1);
        chk("pushpop_empty_unf", unf0, 1'b1);
        cyc(1'b0, 1'b1, '0, 1'b1);
        chk("pushpop_empty_data", dout0, 12'h055);

        async_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 12'h300 + 12'(i), 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 12'h100 + 12'(i), 1'b0);
            chk("wrap_count", cnt0, 4'd8);
            chk("wrap_ovf", ovf0, 1'b0);
            chk("wrap_dout", dout0, 12'h300 + 12'(i));
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, '0, 1'b0);
            chk("wrap_drain", dout0, 12'h100 + 12'(i));
        end

        async_reset();
        cyc(1'b1, 1'b0, 12'h00C, 1'b0);
        chk("fwft_first", dout1, 12'h00C);
        cyc(1'b1, 1'b0, 12'h00D, 1'b0);
        chk("fwft_hold", dout1, 12'h00C);
        cyc(1'b0, 1'b1, '0, 1'b0);
        chk("fwft_next", dout1, 12'h00D);
        cyc(1'b0, 1'b1, '0, 1'b0);
        chk("fwft_empty", empty1, 1'b1);
        chk("fwft_zero", dout1, 12'h000);

        thr_af = 4'd9;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 12'h400 + 12'(i), 1'b0);
        chk("af_thr_above_depth", af0, 1'b0);
        thr_af = 4'd6;

        async_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 12'h500 + 12'(i), 1'b0);
        cyc(1'b0, 1'b1, '0, 1'b0);
        cyc(1'b1, 1'b0, 12'h5AA, 1'b0);
        reset = 1'b1;
        #2;
        chk("midrst_count", cnt0, 4'd0);
        chk("midrst_empty", empty0, 1'b1);
        chk("midrst_dout", dout0, 12'h000);
        q.delete(); m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
        #1 reset = 1'b0;
        cyc(1'b0, 1'b1, '0, 1'b0);
        chk("post_rst_pop_unf", unf0, 1'b1);

        for (int i = 0; i < 1200; i++) begin
            int pp, pq;
            if (i % 100 == 0) begin
                thr_af = 4'($urandom_range(0, 15));
                thr_ae = 4'($urandom_range(0, 15));
            end
            pp = ((i / 150) % 2 == 0) ? 70 : 30;
            pq = 100 - pp;
            if ($urandom_range(0, 299) == 0) begin
                @(negedge clk);
                #1;
                async_reset();
                @(posedge clk); #1;
            end else begin
                cyc($urandom_range(0, 99) < pp, $urandom_range(0, 99) < pq,
                    DW'($urandom), $urandom_range(0, 19) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
